// File: rtl/fp32_pkg.sv
// Shared IEEE-754 single-precision constants and types for the FFT float units
// (div_float, mul_float).
package fp32_pkg;

  localparam int FP_W      = 32;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_MANT_W = 24;

  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam int          FP_BIAS    = 127;
  localparam int          FP_EXP_MAX = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Signed infinity or signed zero; these are the only non-NaN special encodings produced.
  function automatic logic [31:0] fp_signed_special(input logic sign, input logic is_inf);
    fp_signed_special = {sign, (is_inf ? 8'hFF : 8'h00), 23'd0};
  endfunction

endpackage

// File: rtl/fp32_unpack.sv
// Splits an fp32 word into sign/exponent/mantissa and classifies it.
// Denormals are reported as zero and carry a zero mantissa.
module fp32_unpack
  import fp32_pkg::*;
(
  input  logic [FP_W-1:0]      i_op,
  output logic                 o_sign,
  output logic [FP_EXP_W-1:0]  o_exp,
  output logic [FP_MANT_W-1:0] o_mant,
  output logic                 o_is_zero,
  output logic                 o_is_inf,
  output logic                 o_is_nan
);

  logic [FP_FRAC_W-1:0] w_frac;
  logic                 w_exp_max;

  assign o_sign    = i_op[31];
  assign o_exp     = i_op[30:23];
  assign w_frac    = i_op[22:0];
  assign w_exp_max = (o_exp == 8'hFF);

  assign o_is_zero = (o_exp == 8'h00);
  assign o_is_inf  = w_exp_max && (w_frac == 23'd0);
  assign o_is_nan  = w_exp_max && (w_frac != 23'd0);
  assign o_mant    = o_is_zero ? 24'd0 : {1'b1, w_frac};

endmodule

// File: rtl/div_float.sv
// Sequential fp32 divider: restoring radix-2 mantissa division, one quotient bit
// per clock, followed by round-to-nearest-even normalisation.
module div_float
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero
);

  div_state_t  r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_loaded;
  logic [4:0]  r_cnt;
  logic [24:0] r_rem;
  logic [23:0] r_mb;
  logic [25:0] r_q;
  logic        r_sign;
  logic [9:0]  r_diff;
  logic        r_ready;
  logic        r_done;
  logic [31:0] r_result;
  logic        r_dbz;

  logic        w_sa, w_sb;
  logic [7:0]  w_ea, w_eb;
  logic [23:0] w_ma, w_mb;
  logic        w_za, w_zb, w_ia, w_ib, w_na, w_nb;

  fp32_unpack u_unpack_a (
    .i_op      (r_a),
    .o_sign    (w_sa),
    .o_exp     (w_ea),
    .o_mant    (w_ma),
    .o_is_zero (w_za),
    .o_is_inf  (w_ia),
    .o_is_nan  (w_na)
  );

  fp32_unpack u_unpack_b (
    .i_op      (r_b),
    .o_sign    (w_sb),
    .o_exp     (w_eb),
    .o_mant    (w_mb),
    .o_is_zero (w_zb),
    .o_is_inf  (w_ib),
    .o_is_nan  (w_nb)
  );

  logic        w_sign;
  logic        w_special;
  logic [31:0] w_spec_res;
  logic        w_spec_dbz;

  assign w_sign = w_sa ^ w_sb;

  // Special-operand classification, highest priority first.
  always_comb begin
    w_special  = 1'b1;
    w_spec_res = 32'd0;
    w_spec_dbz = 1'b0;
    if (w_na || w_nb) begin
      w_spec_res = FP_QNAN;
    end else if ((w_ia && w_ib) || (w_za && w_zb)) begin
      w_spec_res = FP_QNAN;
    end else if (w_ia) begin
      w_spec_res = fp_signed_special(w_sign, 1'b1);
    end else if (w_ib || w_za) begin
      w_spec_res = fp_signed_special(w_sign, 1'b0);
    end else if (w_zb) begin
      w_spec_res = fp_signed_special(w_sign, 1'b1);
      w_spec_dbz = 1'b1;
    end else begin
      w_special  = 1'b0;
    end
  end

  logic        w_ge;
  logic [24:0] w_rem_sub;
  logic [24:0] w_rem_next;

  assign w_ge       = (r_rem >= {1'b0, r_mb});
  assign w_rem_sub  = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
  assign w_rem_next = w_rem_sub << 1;

  logic               w_int;
  logic [22:0]        w_frac;
  logic               w_guard;
  logic               w_sticky;
  logic               w_lsb;
  logic               w_inc;
  logic               w_carry;
  logic [22:0]        w_frac_rnd;
  logic signed [10:0] w_exp_pre;
  logic signed [10:0] w_exp_fin;
  logic [31:0]        w_norm_res;

  assign w_int      = r_q[25];
  assign w_frac     = w_int ? r_q[24:2] : r_q[23:1];
  assign w_guard    = w_int ? r_q[1] : r_q[0];
  assign w_sticky   = (w_int & r_q[0]) | (r_rem != 25'd0);
  assign w_lsb      = w_frac[0];
  assign w_inc      = w_guard & (w_sticky | w_lsb);
  // A carry out of the fraction means the mantissa rounded up to 2.0; the fraction is then already zero.
  assign {w_carry, w_frac_rnd} = {1'b0, w_frac} + {23'd0, w_inc};
  assign w_exp_pre  = $signed({r_diff[9], r_diff}) + (w_int ? 11'sd127 : 11'sd126);
  assign w_exp_fin  = w_exp_pre + $signed({10'd0, w_carry});

  // Exponent range check: overflow to signed infinity, underflow flushed to signed zero.
  always_comb begin
    w_norm_res = {r_sign, w_exp_fin[7:0], w_frac_rnd};
    if (w_exp_fin >= 11'sd255) begin
      w_norm_res = fp_signed_special(r_sign, 1'b1);
    end else if (w_exp_fin <= 11'sd0) begin
      w_norm_res = fp_signed_special(r_sign, 1'b0);
    end else begin
      w_norm_res = {r_sign, w_exp_fin[7:0], w_frac_rnd};
    end
  end

  // Control FSM plus divider datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_loaded <= 1'b0;
      r_cnt    <= 5'd0;
      r_rem    <= 25'd0;
      r_mb     <= 24'd0;
      r_q      <= 26'd0;
      r_sign   <= 1'b0;
      r_diff   <= 10'd0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_result <= 32'd0;
      r_dbz    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_loaded <= 1'b0;
            r_ready  <= 1'b0;
            r_state  <= DIV;
          end else begin
            r_state  <= IDLE;
          end
        end
        DIV: begin
          if (!r_loaded) begin
            // The first DIV cycle resolves special operands or seeds the remainder.
            if (w_special) begin
              r_result <= w_spec_res;
              r_dbz    <= w_spec_dbz;
              r_done   <= 1'b1;
              r_ready  <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_rem    <= {1'b0, w_ma};
              r_mb     <= w_mb;
              r_q      <= 26'd0;
              r_sign   <= w_sign;
              r_diff   <= {2'b00, w_ea} - {2'b00, w_eb};
              r_cnt    <= 5'd0;
              r_loaded <= 1'b1;
            end
          end else begin
            r_q   <= {r_q[24:0], w_ge};
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd25) begin
              r_state <= NORM;
            end else begin
              r_state <= DIV;
            end
          end
        end
        NORM: begin
          r_result <= w_norm_res;
          r_dbz    <= 1'b0;
          r_done   <= 1'b1;
          r_ready  <= 1'b1;
          r_state  <= DONE;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign done        = r_done;
  assign result      = r_result;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_float.sv
// Self-checking bench for div_float: a scoreboard queue holds the expected result,
// flag and latency of every accepted request, and a monitor retires them on done.
module tb_div_float;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          lat;
    int          acc;
  } sb_entry_t;

  sb_entry_t sb[$];
  sb_entry_t mon_e;
  int        cyc;
  int        n_checks;
  int        n_fail;

  div_float dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .ready       (ready),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Retire one scoreboard entry per done pulse.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check_eq("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check_eq("result", result, mon_e.res);
        check_eq("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
        check_eq("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
      end
    end
  end

  task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] er, input logic ed, input int lat);
    sb_entry_t e;
    int n;
    n = 0;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("issue_ready", {31'd0, ready}, 32'd1);
    a     = ia;
    b     = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    e.res = er;
    e.dbz = ed;
    e.lat = lat;
    e.acc = cyc;
    sb.push_back(e);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check_eq("drain", 32'(sb.size()), 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = 32'd0;
    b        = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'd0, ready}, 32'd1);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_result", result, 32'd0);
    check_eq("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 7.5/3.0, then -6/4 issued in the done cycle with no bubble.
    issue(32'h40F0_0000, 32'h4040_0000, 32'h4020_0000, 1'b0, 28);
    wait_done();
    issue(32'hC0C0_0000, 32'h4080_0000, 32'hBFC0_0000, 1'b0, 28);
    wait_drain();

    issue(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 28);
    wait_drain();
    issue(32'h3E00_0000, 32'h3F00_0000, 32'h3E80_0000, 1'b0, 28);
    wait_drain();

    issue(32'h40A0_0000, 32'h0000_0000, 32'h7F80_0000, 1'b1, 1);
    wait_drain();
    issue(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1);
    wait_drain();
    issue(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1);
    wait_drain();
    issue(32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1);
    wait_drain();
    issue(32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000, 1'b0, 1);
    wait_drain();
    issue(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0, 1);
    wait_drain();
    issue(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1);
    wait_drain();

    issue(32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b0, 28);
    wait_drain();
    issue(32'h0080_0000, 32'h4080_0000, 32'h0000_0000, 1'b0, 28);
    wait_drain();

    // A start while busy must neither be accepted nor resample the operands.
    issue(32'h40F0_0000, 32'h4040_0000, 32'h4020_0000, 1'b0, 28);
    repeat (5) @(negedge clk);
    a     = 32'h3F80_0000;
    b     = 32'h4040_0000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);

    // Reset mid-operation aborts it without a done pulse.
    issue(32'h40F0_0000, 32'h4040_0000, 32'h4020_0000, 1'b0, 28);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_eq("abort_ready", {31'd0, ready}, 32'd1);
    check_eq("abort_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (35) @(negedge clk);
    check_eq("post_abort_result", result, 32'd0);
    check_eq("post_abort_ready", {31'd0, ready}, 32'd1);
    check_eq("post_abort_dbz", {31'd0, div_by_zero}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
